// File: rtl/elevator_pkg.sv
// Shared constants, FSM state type and floor helpers for the two-car
// hall-call dispatcher.
package elevator_pkg;

   localparam int         NUM_FLOORS     = 5;
   localparam logic [2:0] FLOOR_MIN      = 3'd1;
   localparam logic [2:0] FLOOR_MAX      = 3'd5;

   localparam logic [1:0] DIR_IDLE       = 2'b00;
   localparam logic [1:0] DIR_UP         = 2'b10;
   localparam logic [1:0] DIR_DOWN       = 2'b01;

   localparam logic [3:0] COST_PENALTY   = 4'd8;
   localparam logic [3:0] COST_INVALID   = 4'd15;

   localparam int         TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_SCAN  = 2'd0,
      ST_OFFER = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // A car reporting a floor outside 1..5 is out of service.
   function automatic logic floor_valid(input logic [2:0] f);
      return (f >= FLOOR_MIN) && (f <= FLOOR_MAX);
   endfunction

   // One-hot per-floor mask (bit i = floor i+1); empty for invalid floors.
   function automatic logic [4:0] floor_onehot(input logic [2:0] f);
      logic [4:0] m;
      m = 5'd0;
      if (floor_valid(f)) m = 5'(1) << (f - FLOOR_MIN);
      return m;
   endfunction

endpackage

// File: rtl/dispatch_cost.sv
// Combinational cost of serving one hall call with one car.
// Lower is better; COST_INVALID means the car must not be chosen.
module dispatch_cost
   import elevator_pkg::*;
(
   input  logic [2:0] i_call_floor,
   input  logic       i_call_up,
   input  logic [2:0] i_car_floor,
   input  logic [1:0] i_car_dir,
   input  logic       i_excluded,
   output logic [3:0] o_cost
);

   logic [2:0] w_dist;
   logic       w_moving;
   logic       w_toward;

   // Distance to the call plus a penalty unless the car is idle or already heading there
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_dist   = (i_call_floor >= i_car_floor) ? (i_call_floor - i_car_floor)
                                               : (i_car_floor - i_call_floor);
      w_moving = (i_car_dir != DIR_IDLE) && (i_car_dir != (DIR_UP | DIR_DOWN));
      w_toward = ((i_car_dir == DIR_UP)   &&  i_call_up && (i_call_floor >= i_car_floor)) ||
                 ((i_car_dir == DIR_DOWN) && !i_call_up && (i_call_floor <= i_car_floor));
      o_cost   = {1'b0, w_dist};
      if (!floor_valid(i_car_floor) || i_excluded)
         o_cost = COST_INVALID;
      else if (w_moving && !w_toward)
         o_cost = {1'b0, w_dist} + COST_PENALTY;
   end

endmodule

// File: rtl/elevator_dispatcher.sv
// Two-car hall-call dispatcher: latches hall calls, picks the lowest pending
// call, offers it to the cheaper car, and tracks assigned calls until arrival.
// Optional feature: define DISPATCH_TIMEOUT_EN to withdraw offers left
// unaccepted for TIMEOUT_CYCLES and exclude the refusing car once.
module elevator_dispatcher
   import elevator_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] hall_up,
   input  logic [4:0] hall_down,
   input  logic [2:0] car0_floor,
   input  logic [2:0] car1_floor,
   input  logic [1:0] car0_dir,
   input  logic [1:0] car1_dir,
   input  logic [1:0] arrive,
   output logic [1:0] asg_valid,
   output logic [2:0] asg_floor,
   output logic       asg_up,
   input  logic [1:0] asg_ready,
   output logic [4:0] lamp_up,
   output logic [4:0] lamp_down
);

   state_t     r_state, w_state_nxt;
   logic [4:0] r_pend_up, r_pend_dn, r_asgd_up, r_asgd_dn;
   logic [4:0] r_own_up, r_own_dn;
   logic [4:0] r_lamp_up, r_lamp_dn;
   logic       r_rr, r_car, r_asg_up;
   logic [2:0] r_asg_floor;

   logic [4:0] w_clr, w_offer_oh, w_rev_up, w_rev_dn, w_acc_up, w_acc_dn;
   logic [4:0] w_pend_up_nxt, w_pend_dn_nxt, w_asgd_up_nxt, w_asgd_dn_nxt;
   logic [4:0] w_scan_up, w_scan_dn;
   logic [1:0] w_oos, w_asg_valid;
   logic       w_in_scan, w_offer_clr, w_accept, w_timeout;
   logic       w_sel_found, w_sel_up, w_can_assign, w_tie, w_pick;
   logic [2:0] w_sel_floor;
   logic [3:0] w_cost0, w_cost1;
   logic       w_excl0, w_excl1;

   assign w_clr       = (arrive[0] ? floor_onehot(car0_floor) : 5'd0) |
                        (arrive[1] ? floor_onehot(car1_floor) : 5'd0);
   assign w_oos       = {!floor_valid(car1_floor), !floor_valid(car0_floor)};
   assign w_in_scan   = (r_state != ST_OFFER) && (r_state != ST_HOLD);
   assign w_offer_oh  = floor_onehot(r_asg_floor);
   assign w_offer_clr = |(w_offer_oh & w_clr);
   assign w_accept    = (r_state == ST_OFFER) && asg_ready[r_car] && !w_offer_clr;
   assign w_scan_up   = r_pend_up & ~w_clr;
   assign w_scan_dn   = r_pend_dn & ~w_clr;

   // Next pending/assigned sets: new calls, owner-lost reverts, acceptance, then arrival clears win
   always_comb begin
      w_rev_up = 5'd0;
      w_rev_dn = 5'd0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         w_rev_up[i] = r_asgd_up[i] & w_oos[r_own_up[i]];
         w_rev_dn[i] = r_asgd_dn[i] & w_oos[r_own_dn[i]];
      end
      w_acc_up      = (w_accept &&  r_asg_up) ? w_offer_oh : 5'd0;
      w_acc_dn      = (w_accept && !r_asg_up) ? w_offer_oh : 5'd0;
      w_pend_up_nxt = (r_pend_up | (hall_up   & ~r_asgd_up) | w_rev_up) & ~w_acc_up & ~w_clr;
      w_pend_dn_nxt = (r_pend_dn | (hall_down & ~r_asgd_dn) | w_rev_dn) & ~w_acc_dn & ~w_clr;
      w_asgd_up_nxt = ((r_asgd_up & ~w_rev_up) | w_acc_up) & ~w_clr;
      w_asgd_dn_nxt = ((r_asgd_dn & ~w_rev_dn) | w_acc_dn) & ~w_clr;
   end

   // Pick the lowest pending floor; at one floor the up call beats the down call
   always_comb begin
      w_sel_found = 1'b0;
      w_sel_floor = FLOOR_MIN;
      w_sel_up    = 1'b0;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (w_scan_dn[i]) begin
            w_sel_found = 1'b1;
            w_sel_floor = 3'(i + 1);
            w_sel_up    = 1'b0;
         end
         if (w_scan_up[i]) begin
            w_sel_found = 1'b1;
            w_sel_floor = 3'(i + 1);
            w_sel_up    = 1'b1;
         end
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   logic [3:0] r_tmo_cnt;
   logic       r_excl_valid, r_excl_car, r_excl_up;
   logic [2:0] r_excl_floor;
   logic       w_excl_hit;

   assign w_excl_hit = r_excl_valid && w_sel_found &&
                       (r_excl_floor == w_sel_floor) && (r_excl_up == w_sel_up);
   assign w_excl0    = w_excl_hit && !r_excl_car;
   assign w_excl1    = w_excl_hit &&  r_excl_car;
   assign w_timeout  = (r_state == ST_OFFER) && !w_accept && !w_offer_clr &&
                       (r_tmo_cnt == 4'(TIMEOUT_CYCLES - 1));

   // Offer age counter and one-shot exclusion of the car that let an offer expire
   always_ff @(posedge clock) begin
      if (reset) begin
         r_tmo_cnt    <= 4'd0;
         r_excl_valid <= 1'b0;
         r_excl_car   <= 1'b0;
         r_excl_up    <= 1'b0;
         r_excl_floor <= FLOOR_MIN;
      end else begin
         r_tmo_cnt <= (r_state == ST_OFFER) ? r_tmo_cnt + 4'd1 : 4'd0;
         if (w_timeout) begin
            r_excl_valid <= 1'b1;
            r_excl_car   <= r_car;
            r_excl_up    <= r_asg_up;
            r_excl_floor <= r_asg_floor;
         end else if (w_in_scan && w_excl_hit) begin
            r_excl_valid <= 1'b0;
         end
      end
   end
`else
   assign w_excl0   = 1'b0;
   assign w_excl1   = 1'b0;
   assign w_timeout = 1'b0;
`endif

   dispatch_cost u_cost0 (
      .i_call_floor (w_sel_floor),
      .i_call_up    (w_sel_up),
      .i_car_floor  (car0_floor),
      .i_car_dir    (car0_dir),
      .i_excluded   (w_excl0),
      .o_cost       (w_cost0)
   );

   dispatch_cost u_cost1 (
      .i_call_floor (w_sel_floor),
      .i_call_up    (w_sel_up),
      .i_car_floor  (car1_floor),
      .i_car_dir    (car1_dir),
      .i_excluded   (w_excl1),
      .o_cost       (w_cost1)
   );

   assign w_can_assign = w_sel_found && !((w_cost0 == COST_INVALID) && (w_cost1 == COST_INVALID));
   assign w_tie        = (w_cost0 == w_cost1);
   assign w_pick       = w_tie ? r_rr : (w_cost1 < w_cost0);

   // FSM next state and the offer strobe
   always_comb begin
      w_state_nxt = r_state;
      w_asg_valid = 2'b00;
      case (r_state)
         ST_OFFER: begin
            w_asg_valid[r_car] = 1'b1;
            if (w_offer_clr)                w_state_nxt = ST_SCAN;
            else if (w_accept || w_timeout) w_state_nxt = ST_HOLD;
         end
         ST_HOLD:  w_state_nxt = ST_SCAN;
         default:  w_state_nxt = w_can_assign ? ST_OFFER : ST_SCAN;
      endcase
   end

   // FSM state register
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) r_state <= ST_SCAN;
      else       r_state <= w_state_nxt;
   end

   // Call bookkeeping, lamps, round-robin pointer and the latched offer
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend_up   <= 5'd0;
         r_pend_dn   <= 5'd0;
         r_asgd_up   <= 5'd0;
         r_asgd_dn   <= 5'd0;
         r_lamp_up   <= 5'd0;
         r_lamp_dn   <= 5'd0;
         r_rr        <= 1'b0;
         r_car       <= 1'b0;
         r_asg_floor <= FLOOR_MIN;
         r_asg_up    <= 1'b0;
      end else begin
         r_pend_up <= w_pend_up_nxt;
         r_pend_dn <= w_pend_dn_nxt;
         r_asgd_up <= w_asgd_up_nxt;
         r_asgd_dn <= w_asgd_dn_nxt;
         r_lamp_up <= w_pend_up_nxt | w_asgd_up_nxt;
         r_lamp_dn <= w_pend_dn_nxt | w_asgd_dn_nxt;
         if (w_in_scan && w_can_assign) begin
            r_asg_floor <= w_sel_floor;
            r_asg_up    <= w_sel_up;
            r_car       <= w_pick;
            if (w_tie) r_rr <= !r_rr;
         end
      end
   end

   // Owner car of each assigned call
   always_ff @(posedge clock) begin
      // NOTE: owner bits are not reset; they are only read while the matching asgd bit is set.
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (w_acc_up[i]) r_own_up[i] <= r_car;
         if (w_acc_dn[i]) r_own_dn[i] <= r_car;
      end
   end

   assign asg_valid = w_asg_valid;
   assign asg_floor = r_asg_floor;
   assign asg_up    = r_asg_up;
   assign lamp_up   = r_lamp_up;
   assign lamp_down = r_lamp_dn;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher with an offer scoreboard.
module tb_elevator_dispatcher;

   logic       clock, reset;
   logic [4:0] hall_up, hall_down;
   logic [2:0] car0_floor, car1_floor;
   logic [1:0] car0_dir, car1_dir;
   logic [1:0] arrive, asg_valid, asg_ready;
   logic [2:0] asg_floor;
   logic       asg_up;
   logic [4:0] lamp_up, lamp_down;

   typedef struct packed {
      logic [1:0] valid;
      logic [2:0] floor;
      logic       up;
   } offer_t;

   offer_t sb[$];
   int     n_vec  = 0;
   int     n_fail = 0;

   elevator_dispatcher dut (
      .clock      (clock),
      .reset      (reset),
      .hall_up    (hall_up),
      .hall_down  (hall_down),
      .car0_floor (car0_floor),
      .car1_floor (car1_floor),
      .car0_dir   (car0_dir),
      .car1_dir   (car1_dir),
      .arrive     (arrive),
      .asg_valid  (asg_valid),
      .asg_floor  (asg_floor),
      .asg_up     (asg_up),
      .asg_ready  (asg_ready),
      .lamp_up    (lamp_up),
      .lamp_down  (lamp_down)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_hall(input logic [4:0] up, input logic [4:0] dn);
      hall_up   = up;
      hall_down = dn;
      step();
      hall_up   = 5'd0;
      hall_down = 5'd0;
   endtask

   task automatic do_arrive(input logic [1:0] a);
      arrive = a;
      step();
      arrive = 2'b00;
   endtask

   task automatic accept(input logic [1:0] car);
      asg_ready = car;
      step();
      asg_ready = 2'b00;
   endtask

   // Wait (bounded) for an offer, then pop the scoreboard and compare it.
   task automatic expect_offer(input string tag, output int lat, output logic [1:0] car);
      offer_t e;
      lat = 0;
      car = 2'b00;
      while (asg_valid == 2'b00 && lat < 40) begin
         step();
         lat++;
      end
      if (asg_valid == 2'b00) begin
         check({tag, " offer timeout"}, 32'd0, 32'd1);
      end else if (sb.size() == 0) begin
         check({tag, " unexpected offer"}, 32'(asg_valid), 32'd0);
      end else begin
         e   = sb.pop_front();
         car = e.valid;
         check({tag, " valid"}, 32'(asg_valid), 32'(e.valid));
         check({tag, " floor"}, 32'(asg_floor), 32'(e.floor));
         check({tag, " up"},    32'(asg_up),    32'(e.up));
      end
   endtask

   task automatic expect_no_offer(input string tag, input int n);
      logic [1:0] seen;
      seen = 2'b00;
      for (int k = 0; k < n; k++) begin
         seen |= asg_valid;
         step();
      end
      seen |= asg_valid;
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      int         lat;
      logic [1:0] car;
      reset = 1'b1; hall_up = 5'd0; hall_down = 5'd0; arrive = 2'b00; asg_ready = 2'b00;
      car0_floor = 3'd1; car1_floor = 3'd5; car0_dir = 2'b00; car1_dir = 2'b00;
      step(); step();
      check("rst asg_valid", 32'(asg_valid), 32'd0);
      check("rst asg_floor", 32'(asg_floor), 32'd1);
      check("rst asg_up",    32'(asg_up),    32'd0);
      check("rst lamp_up",   32'(lamp_up),   32'd0);
      check("rst lamp_down", 32'(lamp_down), 32'd0);
      reset = 1'b0;
      step();

      // Floor 3 up, cars idle at 1 and 5: tie at distance 2, rr=0 picks car0.
      sb.push_back('{2'b01, 3'd3, 1'b1});
      pulse_hall(5'b00100, 5'd0);
      check("f3 lamp_up cycle1", 32'(lamp_up), 32'b00100);
      expect_offer("f3 up", lat, car);
      check("f3 scan latency", 32'(lat), 32'd1);
      step(); step(); step();
      check("f3 valid held", 32'(asg_valid), 32'b01);
      check("f3 floor held", 32'(asg_floor), 32'd3);
      accept(car);
      check("f3 hold valid", 32'(asg_valid), 32'd0);
      check("f3 lamp assigned", 32'(lamp_up), 32'b00100);
      expect_no_offer("f3 no reoffer", 3);
      car0_floor = 3'd3;
      do_arrive(2'b01);
      car0_floor = 3'd1;
      check("f3 lamp cleared", 32'(lamp_up), 32'd0);

      // Tie alternation: both idle at 2, call floor 4 up, twice.
      reset = 1'b1; step(); reset = 1'b0;
      car0_floor = 3'd2; car1_floor = 3'd2;
      sb.push_back('{2'b01, 3'd4, 1'b1});
      pulse_hall(5'b01000, 5'd0);
      expect_offer("tie1", lat, car);
      accept(car);
      car0_floor = 3'd4; do_arrive(2'b01); car0_floor = 3'd2;
      sb.push_back('{2'b10, 3'd4, 1'b1});
      pulse_hall(5'b01000, 5'd0);
      expect_offer("tie2", lat, car);
      accept(car);
      car1_floor = 3'd4; do_arrive(2'b10); car1_floor = 3'd2;
      check("tie lamps clear", 32'(lamp_up), 32'd0);

      // Car0 at 4 moving up (cost 9) vs car1 idle at 1 (cost 2) for floor 3 down.
      car0_floor = 3'd4; car0_dir = 2'b10; car1_floor = 3'd1;
      sb.push_back('{2'b10, 3'd3, 1'b0});
      pulse_hall(5'd0, 5'b00100);
      check("cost lamp_down", 32'(lamp_down), 32'b00100);
      expect_offer("cost car1", lat, car);
      accept(2'b01);
      check("wrong car ignored", 32'(asg_valid), 32'b10);
      accept(car);
      car1_floor = 3'd3;
      do_arrive(2'b10);
      check("arrive clears lamp_down", 32'(lamp_down), 32'd0);
      expect_no_offer("arrive cleared pend", 3);

      // Same call, then car1 drops out of service while owning it: reoffered to car0.
      car1_floor = 3'd1;
      sb.push_back('{2'b10, 3'd3, 1'b0});
      pulse_hall(5'd0, 5'b00100);
      expect_offer("oos first", lat, car);
      accept(car);
      car1_floor = 3'd0;
      sb.push_back('{2'b01, 3'd3, 1'b0});
      expect_offer("oos reoffer", lat, car);
      check("oos lamp kept", 32'(lamp_down), 32'b00100);
      accept(car);
      car0_floor = 3'd3; car0_dir = 2'b00;
      do_arrive(2'b01);
      car0_floor = 3'd1; car1_floor = 3'd5;
      check("oos cleared", 32'(lamp_down), 32'd0);

      // Reset in mid-offer with ready high: nothing recorded.
      sb.push_back('{2'b01, 3'd1, 1'b1});
      pulse_hall(5'b00001, 5'd0);
      expect_offer("rst offer", lat, car);
      reset = 1'b1; asg_ready = 2'b01;
      step();
      reset = 1'b0; asg_ready = 2'b00;
      check("rst abort valid", 32'(asg_valid), 32'd0);
      check("rst abort lamp",  32'(lamp_up),   32'd0);
      expect_no_offer("rst abort idle", 3);
      sb.push_back('{2'b01, 3'd1, 1'b1});
      pulse_hall(5'b00001, 5'd0);
      expect_offer("rst reoffer", lat, car);
      accept(car);
      do_arrive(2'b01);

      // Priority and throughput: floor 2 up, floor 2 down, floor 4 up.
      sb.push_back('{2'b01, 3'd2, 1'b1});
      sb.push_back('{2'b01, 3'd2, 1'b0});
      sb.push_back('{2'b10, 3'd4, 1'b1});
      pulse_hall(5'b01010, 5'b00010);
      expect_offer("prio 1", lat, car);
      accept(car);
      expect_offer("prio 2", lat, car);
      check("prio2 latency", 32'(lat), 32'd2);
      accept(car);
      expect_offer("prio 3", lat, car);
      check("prio3 latency", 32'(lat), 32'd2);
      accept(car);
      check("prio lamp_up",   32'(lamp_up),   32'b01010);
      check("prio lamp_down", 32'(lamp_down), 32'b00010);
      car0_floor = 3'd2; car1_floor = 3'd4;
      do_arrive(2'b11);
      check("dual arrive up",   32'(lamp_up),   32'd0);
      check("dual arrive down", 32'(lamp_down), 32'd0);

      // Hall pulse and clearing arrive on the same call in the same cycle.
      hall_up = 5'b00010; arrive = 2'b01;
      step();
      hall_up = 5'd0; arrive = 2'b00;
      check("clear wins lamp", 32'(lamp_up), 32'd0);
      expect_no_offer("clear wins no offer", 3);
      car0_floor = 3'd1; car1_floor = 3'd5;

      // Arrival clears the call under offer: offer withdrawn next cycle.
      sb.push_back('{2'b01, 3'd2, 1'b1});
      pulse_hall(5'b00010, 5'd0);
      expect_offer("arr offer", lat, car);
      car1_floor = 3'd2;
      do_arrive(2'b10);
      check("arr drops valid", 32'(asg_valid), 32'd0);
      check("arr lamp", 32'(lamp_up), 32'd0);
      car1_floor = 3'd5;

      // Both cars out of service: call stays pending until a car returns.
      car0_floor = 3'd0; car1_floor = 3'd7;
      pulse_hall(5'b10000, 5'd0);
      expect_no_offer("both oos", 5);
      check("both oos lamp", 32'(lamp_up), 32'b10000);
      car0_floor = 3'd1;
      sb.push_back('{2'b01, 3'd5, 1'b1});
      expect_offer("oos recover", lat, car);
      accept(car);
      car0_floor = 3'd5; do_arrive(2'b01); car0_floor = 3'd1; car1_floor = 3'd5;

      // Unaccepted offer: withdrawn after 16 cycles with the timeout, else held.
      sb.push_back('{2'b01, 3'd2, 1'b1});
      pulse_hall(5'b00010, 5'd0);
      expect_offer("tmo first", lat, car);
`ifdef DISPATCH_TIMEOUT_EN
      lat = 1;
      while (asg_valid != 2'b00 && lat < 40) begin
         step();
         if (asg_valid != 2'b00) lat++;
      end
      check("tmo offer cycles", 32'(lat), 32'd16);
      sb.push_back('{2'b10, 3'd2, 1'b1});
      expect_offer("tmo other car", lat, car);
`else
      for (int k = 0; k < 40; k++) step();
      check("no tmo still valid", 32'(asg_valid), 32'b01);
`endif
      accept(car);
      car0_floor = 3'd2; do_arrive(2'b01); car0_floor = 3'd1;
      check("final lamps", 32'({lamp_up, lamp_down}), 32'd0);
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
